// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : HD44780 command bytes, FSM state encodings and timer helper
//               shared by the character-LCD driver.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] CMD_FSET_2L = 8'h28;
    localparam logic [7:0] CMD_FSET_1L = 8'h20;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;
    localparam logic [7:0] ROW1_BASE   = 8'h40;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT3A,
        ST_INIT3B,
        ST_INIT3C,
        ST_INIT2,
        ST_FSET,
        ST_DISP,
        ST_CLR,
        ST_ENTRY,
        ST_IDLE,
        ST_ROWADDR,
        ST_CHARS,
        ST_FRAME_END
    } lcd_state_t;

    typedef enum logic [2:0] {
        PH_LOAD,
        PH_WAIT,
        PH_HI,
        PH_HI_W,
        PH_LO,
        PH_LO_W
    } xfer_phase_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHIGH,
        TX_ELOW
    } tx_state_t;

    // Load/advance/start handshake cycles that surround every countdown, so a
    // wait of t cycles lands the next nibble setup exactly t cycles later.
    localparam int unsigned XFER_OVERHEAD = 3;

    function automatic int unsigned wait_load(input int unsigned t);
        return (t > XFER_OVERHEAD) ? (t - XFER_OVERHEAD) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx
// Description : Sends one 4-bit nibble: setup with E low, E high pulse, E low
//               hold, then a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_E     = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [3:0] i_nibble,
    output logic       o_done,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic [3:0] o_lcd_data
);

    localparam int T_MAX = (T_SETUP > T_E) ? T_SETUP : T_E;
    localparam int CNT_W = $clog2(T_MAX + 1);

    tx_state_t        r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic             r_rs, w_rs_n;
    logic [3:0]       r_nib, w_nib_n;
    logic             r_done, w_done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_nib   <= 4'h0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_rs    <= w_rs_n;
            r_nib   <= w_nib_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_rs_n    = r_rs;
        w_nib_n   = r_nib;
        w_done_n  = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (i_start) begin
                    w_rs_n    = i_rs;
                    w_nib_n   = i_nibble;
                    w_cnt_n   = CNT_W'(T_SETUP - 1);
                    w_state_n = TX_SETUP;
                end
            end
            TX_SETUP: begin
                if (r_cnt == '0) begin
                    w_cnt_n   = CNT_W'(T_E - 1);
                    w_state_n = TX_EHIGH;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            TX_EHIGH: begin
                if (r_cnt == '0) begin
                    w_cnt_n   = CNT_W'(T_E - 1);
                    w_state_n = TX_ELOW;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            TX_ELOW: begin
                if (r_cnt == '0) begin
                    w_done_n  = 1'b1;
                    w_state_n = TX_IDLE;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_n = TX_IDLE;
        endcase
    end

    // RS and data stay on the pins after the transfer until the next start.
    assign o_done     = r_done;
    assign o_lcd_e    = (r_state == TX_EHIGH);
    assign o_lcd_rs   = r_rs;
    assign o_lcd_data = r_nib;

endmodule
`default_nettype wire

// File: rtl/lcd_char_driver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_driver
// Description : HD44780 4-bit write-only driver: power-up init, then refreshes
//               a NUM_ROWS x NUM_COLS character buffer to the panel.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_driver
    import lcd_pkg::*;
#(
    parameter int NUM_ROWS = 2,
    parameter int NUM_COLS = 16,
    parameter int T_PWRUP  = 750000,
    parameter int T_INIT   = 205000,
    parameter int T_CLR    = 82000,
    parameter int T_CMD    = 2000,
    parameter int T_SETUP  = 2,
    parameter int T_E      = 12,
    parameter int TMR_W    = 20,
    localparam int ADDR_W  = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              enable,
    output logic              ready,
    output logic              frame_done,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic              lcd_7,
    output logic              lcd_6,
    output logic              lcd_5,
    output logic              lcd_4
);

    localparam int         DEPTH    = NUM_ROWS * NUM_COLS;
    localparam int         COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [7:0] FSET_CMD = (NUM_ROWS == 2) ? CMD_FSET_2L : CMD_FSET_1L;
    localparam logic       ROW_LAST = 1'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    logic [7:0]        r_buf [DEPTH];
    lcd_state_t        r_state, w_state_n;
    xfer_phase_t       r_phase, w_phase_n;
    logic [TMR_W-1:0]  r_tmr, w_tmr_n;
    logic              r_row, w_row_n;
    logic [COL_W-1:0]  r_col, w_col_n;
    logic [7:0]        r_byte, w_byte_n;
    logic              r_ready, w_ready_n;
    logic              r_fdone, w_fdone_n;

    logic [ADDR_W-1:0] w_idx;
    logic [7:0]        w_byte;
    logic [3:0]        w_nib;
    logic [TMR_W-1:0]  w_post;
    logic              w_nib_only;
    logic              w_tx_start;
    logic              w_tx_done;
    logic [3:0]        w_tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH))) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    assign w_idx      = ADDR_W'(r_row) * ADDR_W'(NUM_COLS) + ADDR_W'(r_col);
    assign w_nib_only = (r_state == ST_INIT3A) || (r_state == ST_INIT3B) ||
                        (r_state == ST_INIT3C) || (r_state == ST_INIT2);

    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            ST_INIT3A, ST_INIT3B, ST_INIT3C: w_byte = 8'h03;
            ST_INIT2:   w_byte = 8'h02;
            ST_FSET:    w_byte = FSET_CMD;
            ST_DISP:    w_byte = CMD_DISP_ON;
            ST_CLR:     w_byte = CMD_CLEAR;
            ST_ENTRY:   w_byte = CMD_ENTRY;
            ST_ROWADDR: w_byte = CMD_DDRAM | (r_row ? ROW1_BASE : 8'h00);
            ST_CHARS:   w_byte = r_buf[w_idx];
            default:    w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_post = TMR_W'(wait_load(T_CMD));
        case (r_state)
            ST_PWRUP:  w_post = TMR_W'(wait_load(T_PWRUP));
            ST_INIT3A: w_post = TMR_W'(wait_load(T_INIT));
            ST_CLR:    w_post = TMR_W'(wait_load(T_CLR));
            default:   w_post = TMR_W'(wait_load(T_CMD));
        endcase
    end

    // The low nibble of a byte comes from r_byte, captured when the high
    // nibble started, so buffer writes never split a character.
    assign w_nib = (r_phase == PH_HI) ? w_byte[7:4] :
                   (w_nib_only ? w_byte[3:0] : r_byte[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PWRUP;
            r_phase <= PH_LOAD;
            r_tmr   <= '0;
            r_row   <= 1'b0;
            r_col   <= '0;
            r_byte  <= 8'h00;
            r_ready <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_phase <= w_phase_n;
            r_tmr   <= w_tmr_n;
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_byte  <= w_byte_n;
            r_ready <= w_ready_n;
            r_fdone <= w_fdone_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_phase_n  = r_phase;
        w_tmr_n    = r_tmr;
        w_row_n    = r_row;
        w_col_n    = r_col;
        w_byte_n   = r_byte;
        w_ready_n  = r_ready;
        w_fdone_n  = 1'b0;
        w_tx_start = 1'b0;
        if (r_state == ST_IDLE) begin
            if (enable) begin
                w_state_n = ST_ROWADDR;
                w_phase_n = PH_HI;
                w_row_n   = 1'b0;
                w_col_n   = '0;
            end
        end else if (r_state == ST_FRAME_END) begin
            w_fdone_n = 1'b1;
            w_state_n = ST_IDLE;
        end else begin
            case (r_phase)
                PH_LOAD: begin
                    w_tmr_n   = w_post;
                    w_phase_n = PH_WAIT;
                end
                PH_WAIT: begin
                    if (r_tmr != '0) begin
                        w_tmr_n = r_tmr - TMR_W'(1);
                    end else begin
                        case (r_state)
                            ST_PWRUP:  begin w_state_n = ST_INIT3A; w_phase_n = PH_LO; end
                            ST_INIT3A: begin w_state_n = ST_INIT3B; w_phase_n = PH_LO; end
                            ST_INIT3B: begin w_state_n = ST_INIT3C; w_phase_n = PH_LO; end
                            ST_INIT3C: begin w_state_n = ST_INIT2;  w_phase_n = PH_LO; end
                            ST_INIT2:  begin w_state_n = ST_FSET;   w_phase_n = PH_HI; end
                            ST_FSET:   begin w_state_n = ST_DISP;   w_phase_n = PH_HI; end
                            ST_DISP:   begin w_state_n = ST_CLR;    w_phase_n = PH_HI; end
                            ST_CLR:    begin w_state_n = ST_ENTRY;  w_phase_n = PH_HI; end
                            ST_ENTRY:  begin w_state_n = ST_IDLE;   w_ready_n = 1'b1;  end
                            ST_ROWADDR: begin w_state_n = ST_CHARS; w_phase_n = PH_HI; end
                            ST_CHARS: begin
                                w_phase_n = PH_HI;
                                if (r_col == COL_LAST) begin
                                    w_col_n = '0;
                                    if (r_row == ROW_LAST) begin
                                        w_row_n   = 1'b0;
                                        w_state_n = ST_FRAME_END;
                                    end else begin
                                        w_row_n   = 1'b1;
                                        w_state_n = ST_ROWADDR;
                                    end
                                end else begin
                                    w_col_n = r_col + COL_W'(1);
                                end
                            end
                            default: w_state_n = ST_IDLE;
                        endcase
                    end
                end
                PH_HI: begin
                    w_tx_start = 1'b1;
                    w_byte_n   = w_byte;
                    w_phase_n  = PH_HI_W;
                end
                PH_HI_W: begin
                    if (w_tx_done) w_phase_n = PH_LO;
                end
                PH_LO: begin
                    w_tx_start = 1'b1;
                    w_phase_n  = PH_LO_W;
                end
                PH_LO_W: begin
                    if (w_tx_done) w_phase_n = PH_LOAD;
                end
                default: w_phase_n = PH_LOAD;
            endcase
        end
    end

    lcd_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_E     (T_E)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_tx_start),
        .i_rs       (r_state == ST_CHARS),
        .i_nibble   (w_nib),
        .o_done     (w_tx_done),
        .o_lcd_e    (lcd_e),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_data (w_tx_data)
    );

    assign lcd_rw     = 1'b0;
    assign ready      = r_ready;
    assign frame_done = r_fdone;
    assign lcd_7      = w_tx_data[3];
    assign lcd_6      = w_tx_data[2];
    assign lcd_5      = w_tx_data[1];
    assign lcd_4      = w_tx_data[0];

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_char_driver
// Description : Scoreboard bench for lcd_char_driver (2x4 panel, plus a 2x3
//               instance whose buffer leaves addresses 6 and 7 out of range).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_char_driver;

    localparam int TP = 100, TI = 50, TCL = 40, TCM = 20, TS = 2, TE = 4;
    localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                              4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

    typedef struct { logic rs; logic [3:0] nib; int rise; int width; logic rdy; } obs_t;
    typedef struct { logic rs; logic [3:0] nib; } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, enable = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       a_ready, a_fdone, a_rs, a_rw, a_e, b_ready, b_fdone, b_rs, b_rw, b_e;
    logic [3:0] a_d, b_d;

    obs_t obs_q[$];
    exp_t exp_q[$], obs_b[$], exp_b[$];
    obs_t cur;
    logic [7:0] model_a [8];
    logic [7:0] model_b [6];
    int   checks = 0, errors = 0, cyc = 0, fd_cnt = 0, rel = 0;
    bit   rw_bad = 1'b0, a_high = 1'b0, b_high = 1'b0;

    lcd_char_driver #(.NUM_ROWS(2), .NUM_COLS(4), .T_PWRUP(TP), .T_INIT(TI), .T_CLR(TCL),
                      .T_CMD(TCM), .T_SETUP(TS), .T_E(TE), .TMR_W(20)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .enable(enable), .ready(a_ready), .frame_done(a_fdone), .lcd_rs(a_rs), .lcd_rw(a_rw),
        .lcd_e(a_e), .lcd_7(a_d[3]), .lcd_6(a_d[2]), .lcd_5(a_d[1]), .lcd_4(a_d[0]));

    lcd_char_driver #(.NUM_ROWS(2), .NUM_COLS(3), .T_PWRUP(TP), .T_INIT(TI), .T_CLR(TCL),
                      .T_CMD(TCM), .T_SETUP(TS), .T_E(TE), .TMR_W(20)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .enable(enable), .ready(b_ready), .frame_done(b_fdone), .lcd_rs(b_rs), .lcd_rw(b_rw),
        .lcd_e(b_e), .lcd_7(b_d[3]), .lcd_6(b_d[2]), .lcd_5(b_d[1]), .lcd_4(b_d[0]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_rw !== 1'b0 || b_rw !== 1'b0) rw_bad = 1'b1;
        if (a_fdone === 1'b1) fd_cnt++;
        if (!rst_n) begin
            a_high = 1'b0;
        end else if (a_e === 1'b1 && !a_high) begin
            a_high = 1'b1; cur.rs = a_rs; cur.nib = a_d; cur.rise = cyc; cur.width = 1;
        end else if (a_e === 1'b1) begin
            cur.width++;
        end else if (a_high) begin
            a_high = 1'b0; cur.rdy = a_ready; obs_q.push_back(cur);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_high = 1'b0;
        end else if (b_e === 1'b1 && !b_high) begin
            b_high = 1'b1; obs_b.push_back('{rs: b_rs, nib: b_d});
        end else if (b_e !== 1'b1) begin
            b_high = 1'b0;
        end
    end

    task automatic push_byte_a(input logic rs, input logic [7:0] b);
        exp_q.push_back('{rs: rs, nib: b[7:4]});
        exp_q.push_back('{rs: rs, nib: b[3:0]});
    endtask

    task automatic push_frame_a();
        push_byte_a(1'b0, 8'h80);
        for (int c = 0; c < 4; c++) push_byte_a(1'b1, model_a[c]);
        push_byte_a(1'b0, 8'hC0);
        for (int c = 0; c < 4; c++) push_byte_a(1'b1, model_a[4+c]);
    endtask

    task automatic push_frame_b();
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b = (k == 0) ? 8'h80 : (k == 4) ? 8'hC0 : model_b[(k < 4) ? k - 1 : k - 2];
            exp_b.push_back('{rs: (k % 4 != 0), nib: b[7:4]});
            exp_b.push_back('{rs: (k % 4 != 0), nib: b[3:0]});
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < 8; i++) model_a[i] = 8'h20;
        for (int i = 0; i < 6; i++) model_b[i] = 8'h20;
    endtask

    task automatic write_buf(input int addr, input logic [7:0] data);
        @(negedge clk); wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
        @(negedge clk); wr_en = 1'b0;
        if (addr < 8) model_a[addr] = data;
        if (addr < 6) model_b[addr] = data;
    endtask

    task automatic pulse_enable();
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        for (int k = 0; k < 6000 && obs_q.size() < n; k++) @(negedge clk);
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_obs_b(input int n, output bit ok);
        for (int k = 0; k < 6000 && obs_b.size() < n; k++) @(negedge clk);
        ok = (obs_b.size() >= n);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0;
        reset_models();
        wait_cycles(3);
        checks++;
        if ({a_e, a_rs, a_rw, a_d, a_ready, a_fdone} !== 9'h0) begin
            errors++;
            $display("FAIL reset_outputs: got e/rs/rw/d/ready/fd=%b, expected all 0",
                     {a_e, a_rs, a_rw, a_d, a_ready, a_fdone});
        end
    endtask

    task automatic test_init();
        bit ok; obs_t o; int g;
        @(negedge clk); rst_n = 1'b1; rel = cyc;
        for (int i = 0; i < 12; i++) exp_q.push_back('{rs: 1'b0, nib: INIT_NIBS[i]});
        wait_obs(12, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL init_timeout: got %0d nibbles, expected 12", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].rise - rel != TP + TS) begin
                errors++; $display("FAIL first_e_rise: got %0d cycles, expected %0d", obs_q[0].rise - rel, TP + TS);
            end
            g = obs_q[1].rise - (obs_q[0].rise + obs_q[0].width);
            checks++;
            if (g < TI) begin errors++; $display("FAIL init_gap: got %0d, expected >= %0d", g, TI); end
            g = obs_q[10].rise - (obs_q[9].rise + obs_q[9].width);
            checks++;
            if (g < TCL) begin errors++; $display("FAIL clear_gap: got %0d, expected >= %0d", g, TCL); end
            checks++;
            if (obs_q[11].rdy !== 1'b0) begin
                errors++; $display("FAIL ready_early: got %b before entry-mode done, expected 0", obs_q[11].rdy);
            end
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            exp_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.rs !== e.rs || o.nib !== e.nib || o.width != TE) begin
                errors++;
                $display("FAIL init_nib[%0d]: got rs=%0b nib=%h e_high=%0d, expected rs=%0b nib=%h e_high=%0d",
                         i, o.rs, o.nib, o.width, e.rs, e.nib, TE);
            end
        end
        exp_q.delete();
        for (int k = 0; k < 500 && a_ready !== 1'b1; k++) @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b, expected 1", a_ready); end
        wait_cycles(300);
        checks++;
        if (obs_q.size() != 0 || a_ready !== 1'b1) begin
            errors++; $display("FAIL idle_quiet: got %0d E pulses ready=%b, expected 0 and 1", obs_q.size(), a_ready);
        end
        obs_q.delete(); obs_b.delete();
    endtask

    task automatic run_frame_a(input string name, input bit drop_mid);
        bit ok; obs_t o; exp_t e;
        fd_cnt = 0;
        push_frame_a();
        if (drop_mid) begin
            @(negedge clk); enable = 1'b1;
            wait_obs(15, ok);
            enable = 1'b0;
        end else begin
            pulse_enable();
        end
        wait_obs(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_timeout: got %0d nibbles, expected 20", name, obs_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.rs !== e.rs || o.nib !== e.nib || o.width != TE) begin
                errors++;
                $display("FAIL %s[%0d]: got rs=%0b nib=%h e_high=%0d, expected rs=%0b nib=%h e_high=%0d",
                         name, i, o.rs, o.nib, o.width, e.rs, e.nib, TE);
            end
        end
        exp_q.delete();
        wait_cycles(300);
        checks++;
        if (fd_cnt != 1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end: got frame_done=%0d extra_e=%0d, expected 1 and 0", name, fd_cnt, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_blank_frame();
        run_frame_a("blank_frame", 1'b0);
        obs_b.delete();
    endtask

    task automatic test_write_frame();
        write_buf(0, "A"); write_buf(1, "B"); write_buf(2, "C"); write_buf(3, "D");
        write_buf(4, "w"); write_buf(5, "x"); write_buf(6, "y"); write_buf(7, "z");
        run_frame_a("write_frame", 1'b0);
        obs_b.delete();
    endtask

    task automatic test_oob_write();
        bit ok; exp_t e, o;
        write_buf(6, 8'h55); write_buf(7, 8'h55);
        obs_b.delete();
        push_frame_b();
        run_frame_a("oob_frame_a", 1'b0);
        wait_obs_b(16, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL oob_timeout: got %0d nibbles, expected 16", obs_b.size()); end
        for (int i = 0; exp_b.size() > 0 && obs_b.size() > 0; i++) begin
            e = exp_b.pop_front(); o = obs_b.pop_front(); checks++;
            if (o.rs !== e.rs || o.nib !== e.nib) begin
                errors++;
                $display("FAIL oob_frame_b[%0d]: got rs=%0b nib=%h, expected rs=%0b nib=%h", i, o.rs, o.nib, e.rs, e.nib);
            end
        end
        exp_b.delete(); obs_b.delete();
    endtask

    task automatic test_enable_drop();
        write_buf(6, "y"); write_buf(7, "z");
        run_frame_a("enable_drop", 1'b1);
        obs_b.delete();
    endtask

    task automatic test_reset_mid();
        int k;
        pulse_enable();
        for (k = 0; k < 3000 && !(a_e === 1'b1 && a_rs === 1'b1); k++) @(negedge clk);
        checks++;
        if (k >= 3000) begin errors++; $display("FAIL reset_mid_timeout: got no data E pulse, expected one"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_e, a_rs, a_d, a_ready} !== 7'h0) begin
            errors++;
            $display("FAIL async_reset: got e/rs/d/ready=%b, expected 0 without a clock edge", {a_e, a_rs, a_d, a_ready});
        end
        wait_cycles(3);
        obs_q.delete(); exp_q.delete(); obs_b.delete(); exp_b.delete();
        reset_models();
        test_init();
        test_blank_frame();
    endtask

    initial begin
        test_reset();
        test_init();
        test_blank_frame();
        test_write_frame();
        test_oob_write();
        test_enable_drop();
        test_reset_mid();
        checks++;
        if (rw_bad) begin errors++; $display("FAIL lcd_rw: got 1 at some point, expected 0 throughout"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
